// File: rtl/sigmoid_pkg.sv
// Shared widths, word types and output constants for the sigmoid activation.
// The input is signed Q3.6, the output unsigned Q0.8, the table 9-bit unsigned.
package sigmoid_pkg;

  localparam int IN_W      = 10;
  localparam int IN_FRAC   = 6;
  localparam int OUT_W     = 8;
  localparam int ROM_DEPTH = 513;
  localparam int MAG_W     = 10;
  localparam int ROM_W     = 9;

  typedef logic signed [IN_W-1:0] sig_in_t;
  typedef logic [OUT_W-1:0]       sig_out_t;
  typedef logic [MAG_W-1:0]       sig_mag_t;
  typedef logic [ROM_W-1:0]       sig_rom_t;

  localparam sig_out_t SIG_HALF = 8'h80;
  localparam sig_out_t SIG_MAX  = 8'hFF;
  localparam sig_out_t SIG_MIN  = 8'h00;
  localparam sig_rom_t ROM_FULL = 9'd256;

  // |x| in 10 bits, so x = -512 maps to 512 rather than wrapping.
  function automatic sig_mag_t mag_of(input sig_in_t x);
    sig_mag_t raw;
    raw = sig_mag_t'(x);
    return x[IN_W-1] ? (~raw + sig_mag_t'(1)) : raw;
  endfunction

endpackage

// File: rtl/sigmoid_rom.sv
// Positive-half magnitude table: data = round_half_up(256*sigma(addr/64)), addr 0..512.
// Runs of equal values are written as ranges; the table is generated offline.
module sigmoid_rom
  import sigmoid_pkg::*;
(
  input  sig_mag_t addr,
  output sig_rom_t data
);

  always_comb begin
    data = ROM_FULL;
    case (addr) inside
      10'd0:              data = 9'd128;
      10'd1:              data = 9'd129;
      10'd2:              data = 9'd130;
      10'd3:              data = 9'd131;
      10'd4:              data = 9'd132;
      10'd5:              data = 9'd133;
      10'd6:              data = 9'd134;
      10'd7:              data = 9'd135;
      10'd8:              data = 9'd136;
      10'd9:              data = 9'd137;
      10'd10:             data = 9'd138;
      10'd11:             data = 9'd139;
      10'd12:             data = 9'd140;
      10'd13:             data = 9'd141;
      10'd14:             data = 9'd142;
      10'd15:             data = 9'd143;
      10'd16:             data = 9'd144;
      10'd17:             data = 9'd145;
      10'd18:             data = 9'd146;
      10'd19:             data = 9'd147;
      10'd20:             data = 9'd148;
      10'd21:             data = 9'd149;
      10'd22:             data = 9'd150;
      10'd23:             data = 9'd151;
      10'd24:             data = 9'd152;
      10'd25:             data = 9'd153;
      10'd26:             data = 9'd154;
      10'd27:             data = 9'd155;
      10'd28:             data = 9'd156;
      [10'd29:10'd30]:    data = 9'd157;
      10'd31:             data = 9'd158;
      10'd32:             data = 9'd159;
      10'd33:             data = 9'd160;
      10'd34:             data = 9'd161;
      10'd35:             data = 9'd162;
      10'd36:             data = 9'd163;
      10'd37:             data = 9'd164;
      10'd38:             data = 9'd165;
      10'd39:             data = 9'd166;
      10'd40:             data = 9'd167;
      10'd41:             data = 9'd168;
      [10'd42:10'd43]:    data = 9'd169;
      10'd44:             data = 9'd170;
      10'd45:             data = 9'd171;
      10'd46:             data = 9'd172;
      10'd47:             data = 9'd173;
      10'd48:             data = 9'd174;
      10'd49:             data = 9'd175;
      [10'd50:10'd51]:    data = 9'd176;
      10'd52:             data = 9'd177;
      10'd53:             data = 9'd178;
      10'd54:             data = 9'd179;
      10'd55:             data = 9'd180;
      10'd56:             data = 9'd181;
      [10'd57:10'd58]:    data = 9'd182;
      10'd59:             data = 9'd183;
      10'd60:             data = 9'd184;
      10'd61:             data = 9'd185;
      [10'd62:10'd63]:    data = 9'd186;
      10'd64:             data = 9'd187;
      10'd65:             data = 9'd188;
      [10'd66:10'd67]:    data = 9'd189;
      10'd68:             data = 9'd190;
      10'd69:             data = 9'd191;
      10'd70:             data = 9'd192;
      [10'd71:10'd72]:    data = 9'd193;
      10'd73:             data = 9'd194;
      [10'd74:10'd75]:    data = 9'd195;
      10'd76:             data = 9'd196;
      10'd77:             data = 9'd197;
      [10'd78:10'd79]:    data = 9'd198;
      10'd80:             data = 9'd199;
      [10'd81:10'd82]:    data = 9'd200;
      10'd83:             data = 9'd201;
      [10'd84:10'd85]:    data = 9'd202;
      10'd86:             data = 9'd203;
      [10'd87:10'd88]:    data = 9'd204;
      10'd89:             data = 9'd205;
      [10'd90:10'd91]:    data = 9'd206;
      [10'd92:10'd93]:    data = 9'd207;
      10'd94:             data = 9'd208;
      [10'd95:10'd96]:    data = 9'd209;
      [10'd97:10'd98]:    data = 9'd210;
      10'd99:             data = 9'd211;
      [10'd100:10'd101]:  data = 9'd212;
      [10'd102:10'd103]:  data = 9'd213;
      [10'd104:10'd105]:  data = 9'd214;
      10'd106:            data = 9'd215;
      [10'd107:10'd108]:  data = 9'd216;
      [10'd109:10'd110]:  data = 9'd217;
      [10'd111:10'd112]:  data = 9'd218;
      [10'd113:10'd114]:  data = 9'd219;
      [10'd115:10'd116]:  data = 9'd220;
      [10'd117:10'd119]:  data = 9'd221;
      [10'd120:10'd121]:  data = 9'd222;
      [10'd122:10'd123]:  data = 9'd223;
      [10'd124:10'd125]:  data = 9'd224;
      [10'd126:10'd128]:  data = 9'd225;
      [10'd129:10'd130]:  data = 9'd226;
      [10'd131:10'd132]:  data = 9'd227;
      [10'd133:10'd135]:  data = 9'd228;
      [10'd136:10'd138]:  data = 9'd229;
      [10'd139:10'd140]:  data = 9'd230;
      [10'd141:10'd143]:  data = 9'd231;
      [10'd144:10'd146]:  data = 9'd232;
      [10'd147:10'd149]:  data = 9'd233;
      [10'd150:10'd152]:  data = 9'd234;
      [10'd153:10'd156]:  data = 9'd235;
      [10'd157:10'd159]:  data = 9'd236;
      [10'd160:10'd163]:  data = 9'd237;
      [10'd164:10'd167]:  data = 9'd238;
      [10'd168:10'd171]:  data = 9'd239;
      [10'd172:10'd175]:  data = 9'd240;
      [10'd176:10'd180]:  data = 9'd241;
      [10'd181:10'd184]:  data = 9'd242;
      [10'd185:10'd190]:  data = 9'd243;
      [10'd191:10'd195]:  data = 9'd244;
      [10'd196:10'd201]:  data = 9'd245;
      [10'd202:10'd208]:  data = 9'd246;
      [10'd209:10'd215]:  data = 9'd247;
      [10'd216:10'd224]:  data = 9'd248;
      [10'd225:10'd233]:  data = 9'd249;
      [10'd234:10'd244]:  data = 9'd250;
      [10'd245:10'd257]:  data = 9'd251;
      [10'd258:10'd273]:  data = 9'd252;
      [10'd274:10'd295]:  data = 9'd253;
      [10'd296:10'd328]:  data = 9'd254;
      [10'd329:10'd399]:  data = 9'd255;
      [10'd400:10'd512]:  data = 9'd256;
      default:            data = ROM_FULL;
    endcase
  end

endmodule

// File: rtl/sigmoid_lut.sv
// Registered sigmoid: folds negative inputs onto the positive-half table
// using sigma(-x) = 1 - sigma(x), then clamps and registers the result.
module sigmoid_lut
  import sigmoid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-2:0]  din,
  input  logic             sign,
  input  logic             ovf,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout
);

  // Handshake: in_valid qualifies {sign, din, ovf} on the rising edge; out_valid
  // is in_valid one cycle later. There is no backpressure, and dout holds its
  // last result whenever out_valid is low.

  sig_in_t  x;
  sig_mag_t mag;
  sig_rom_t rom_val;
  sig_out_t res;
  sig_out_t dout_d;
  sig_out_t dout_q;
  logic     out_valid_d;
  logic     out_valid_q;

  always_comb begin
    x   = {sign, din};
    mag = mag_of(x);
  end

  sigmoid_rom u_rom (
    .addr (mag),
    .data (rom_val)
  );

  // Negative side: 256 - R(m) never exceeds 128, so the low byte is exact;
  // R(m) = 256 folds to 0 without an extra clamp.
  always_comb begin
    res = SIG_HALF;
    if (ovf) begin
      res = sign ? SIG_MIN : SIG_MAX;
    end else if (sign) begin
      res = sig_out_t'(ROM_FULL - rom_val);
    end else begin
      res = rom_val[ROM_W-1] ? SIG_MAX : rom_val[OUT_W-1:0];
    end
  end

  always_comb begin
    dout_d      = in_valid ? res : dout_q;
    out_valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= SIG_HALF;
      out_valid_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sigmoid_lut.sv
// Self-checking bench for sigmoid_lut: key points, saturation, async reset,
// valid gating and a full monotonic sweep against a real-valued golden model.
module tb_sigmoid_lut;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [8:0] din;
  logic       sign;
  logic       ovf;
  logic       out_valid;
  logic [7:0] dout;

  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_errors;

  sigmoid_lut dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din       (din),
    .sign      (sign),
    .ovf       (ovf),
    .out_valid (out_valid),
    .dout      (dout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Golden model: R(m) = round_half_up(256*sigma(m/64)), folded by sign.
  function automatic int r_of(input int m);
    real s;
    s = 1.0 / (1.0 + $exp(-real'(m) / 64.0));
    return int'($floor(256.0 * s + 0.5));
  endfunction

  function automatic logic [7:0] golden(input logic s, input logic [8:0] d, input logic o);
    int x;
    int r;
    if (o) return s ? 8'h00 : 8'hFF;
    x = s ? (int'(d) - 512) : int'(d);
    if (x >= 0) begin
      r = r_of(x);
      return (r > 255) ? 8'hFF : 8'(r);
    end
    r = r_of(-x);
    return 8'(256 - r);
  endfunction

  // Driver
  task automatic drive(input logic s, input logic [8:0] d, input logic o,
                       input logic v, input logic [7:0] e);
    @(negedge clk);
    sign     = s;
    din      = d;
    ovf      = o;
    in_valid = v;
    if (v) exp_q.push_back(e);
  endtask

  // Scoreboard: every valid output pops one expected value.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      check_eq("sb_avail", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("dout", dout, exp_q.pop_front());
    end
  end

  initial begin
    logic [7:0] prev;
    logic [9:0] xv;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    din      = '0;
    sign     = 1'b0;
    ovf      = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", dout, 8'h80);
    check_eq("rst_vld", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Key points and saturation with literal expectations
    drive(0, 9'h000, 0, 1, 8'h80);
    drive(0, 9'h040, 0, 1, 8'hBB);
    drive(1, 9'h1C0, 0, 1, 8'h45);
    drive(0, 9'h080, 0, 1, 8'hE1);
    drive(1, 9'h180, 0, 1, 8'h1F);
    drive(1, 9'h1FF, 0, 1, 8'h7F);
    drive(0, 9'h1FF, 0, 1, 8'hFF);
    drive(1, 9'h001, 0, 1, 8'h00);
    drive(1, 9'h000, 0, 1, 8'h00);
    drive(0, 9'($urandom_range(0, 511)), 1, 1, 8'hFF);
    drive(1, 9'($urandom_range(0, 511)), 1, 1, 8'h00);
    drive(0, 9'h040, 0, 1, 8'hBB);

    // Asynchronous reset mid-stream with in_valid still high
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_dout", dout, 8'h80);
    check_eq("async_rst_vld", out_valid, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    sign     = 1'b0;
    din      = 9'h040;
    ovf      = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back(8'hBB);

    // Valid gating: the second sample must not load
    drive(0, 9'h040, 0, 1, 8'hBB);
    drive(1, 9'h1C0, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    check_eq("gate_hold", dout, 8'hBB);
    check_eq("gate_vld", out_valid, 0);
    drive(1, 9'($urandom_range(0, 511)), $urandom_range(0, 1), 0, 8'h00);
    @(posedge clk);
    #2;
    check_eq("gate_hold2", dout, 8'hBB);

    // Full sweep -511..511 with monotonic and continuous-valid checks
    prev = 8'h00;
    for (int i = -511; i <= 511; i++) begin
      xv = 10'(i);
      drive(xv[9], xv[8:0], 0, 1, golden(xv[9], xv[8:0], 1'b0));
      if (i > -511) begin
        check_eq("sweep_vld", out_valid, 1);
        if (i > -510) check_eq("mono", (dout >= prev), 1);
        prev = dout;
      end
    end
    @(posedge clk);
    #2;
    check_eq("mono_last", (dout >= prev), 1);
    check_eq("sweep_top", dout, 8'hFF);

    drive(0, 9'h000, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    check_eq("drain", exp_q.size(), 0);
    check_eq("idle_vld", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
